// File: rtl/arb_prio8.sv
// 8-requester arbiter: registered one-hot grant held until done, request drop or hold limit.
// Define ARB_RR_EN for round-robin selection; the default build uses fixed priority (highest index wins).
module arb_prio8 #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   gnt,
  output logic [2:0]         gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [2:0]    win_idx;
  logic          owner_release;
  logic          hold_hit;

`ifdef ARB_RR_EN
  logic [2:0] last_idx;
  logic [2:0] ptr;
  logic [2:0] cand;

  // Walk downward from the slot below the previous owner; the closest set request wins.
  always_comb begin
    ptr     = last_idx - 3'd1;
    win_idx = ptr;
    cand    = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = ptr - 3'(k);
      if (req[cand]) win_idx = cand;
    end
  end
`else
  always_comb begin
    win_idx = 3'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) win_idx = 3'(i);
    end
  end
`endif

  assign owner_release = done[gnt_idx] | ~req[gnt_idx];
  assign hold_hit      = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
`ifdef ARB_RR_EN
      last_idx  <= 3'd0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= BUSY;
            gnt       <= N_REQ'(1) << win_idx;
            gnt_idx   <= win_idx;
            gnt_valid <= 1'b1;
            hold_cnt  <= HW'(1);
`ifdef ARB_RR_EN
            last_idx  <= win_idx;
`endif
          end
        end
        BUSY: begin
          // A normal release takes precedence, so done on the limit cycle never flags a timeout.
          if (owner_release || hold_hit) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
            timeout   <= ~owner_release;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_idx   <= 3'd0;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb_prio8.sv
// Directed self-checking bench for arb_prio8 (built with MAX_HOLD=4); expectations follow ARB_RR_EN.
module tb_arb_prio8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  arb_prio8 #(.N_REQ(8), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_idx,
                           input logic e_valid, input logic e_to);
    check({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    check({tag, ".idx"}, 32'(gnt_idx), 32'(e_idx));
    check({tag, ".valid"}, 32'(gnt_valid), 32'(e_valid));
    check({tag, ".timeout"}, 32'(timeout), 32'(e_to));
    $display("%-12s req=%02h done=%02h gnt=%02h idx=%0d valid=%0b timeout=%0b",
             tag, req, done, gnt, gnt_idx, gnt_valid, timeout);
  endtask

  logic [2:0] exp_idx;

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 8'h00;
    step();
    step();
    check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    check_out("idle0", 8'h00, 3'd0, 1'b0, 1'b0);

    // 1: basic grant with one cycle latency
    req = 8'h06;
    step();
    check_out("t1_grant", 8'h04, 3'd2, 1'b1, 1'b0);

    // 2: done release, turnaround, re-grant
    done = 8'h04;
    step();
    check_out("t2_release", 8'h00, 3'd0, 1'b0, 1'b0);
    done = 8'h00;
    step();
`ifdef ARB_RR_EN
    check_out("t2_regrant", 8'h02, 3'd1, 1'b1, 1'b0);
`else
    check_out("t2_regrant", 8'h04, 3'd2, 1'b1, 1'b0);
`endif
    req = 8'h00;
    step();
    check_out("t2_drop", 8'h00, 3'd0, 1'b0, 1'b0);

    // 6a: done with no requests keeps the arbiter idle
    done = 8'hFF;
    step();
    check_out("t6_idle_a", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    check_out("t6_idle_b", 8'h00, 3'd0, 1'b0, 1'b0);
    done = 8'h00;

    // 3: hold limit of 4 cycles then forced release with timeout
    req = 8'h20;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_out($sformatf("t3_hold%0d", c), 8'h20, 3'd5, 1'b1, 1'b0);
    end
    step();
    check_out("t3_forced", 8'h00, 3'd0, 1'b0, 1'b1);
    step();
    check_out("t3_regrant", 8'h20, 3'd5, 1'b1, 1'b0);
    // done on the limit cycle: normal release, no timeout
    step();
    step();
    step();
    check_out("t3_cnt4", 8'h20, 3'd5, 1'b1, 1'b0);
    done = 8'h20;
    step();
    check_out("t3_done_lim", 8'h00, 3'd0, 1'b0, 1'b0);
    done = 8'h00;
    req  = 8'h00;
    step();
    check_out("t3_after", 8'h00, 3'd0, 1'b0, 1'b0);

    // 5: asynchronous reset mid-grant
    req = 8'h20;
    step();
    check_out("t5_owner5", 8'h20, 3'd5, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("t5_async", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    req   = 8'h01;
    step();
    check_out("t5_idx0", 8'h01, 3'd0, 1'b1, 1'b0);
    done = 8'h01;
    step();
    check_out("t5_release", 8'h00, 3'd0, 1'b0, 1'b0);

    // 4: all requesting, owner releases after one cycle each time
    done = 8'h00;
    req  = 8'hFF;
    for (int g = 0; g < 9; g++) begin
`ifdef ARB_RR_EN
      exp_idx = 3'd7 - 3'(g);
`else
      exp_idx = 3'd7;
`endif
      step();
      check_out($sformatf("t4_g%0d", g), 8'h01 << exp_idx, exp_idx, 1'b1, 1'b0);
      done = 8'h01 << exp_idx;
      step();
      check_out($sformatf("t4_rel%0d", g), 8'h00, 3'd0, 1'b0, 1'b0);
      done = 8'h00;
    end
    req = 8'h00;
    step();

    // 6b: done and req changes on non-owner lines are ignored
    req = 8'h08;
    step();
    check_out("t6_owner3", 8'h08, 3'd3, 1'b1, 1'b0);
    done = 8'h10;
    step();
    check_out("t6_nodone", 8'h08, 3'd3, 1'b1, 1'b0);
    done = 8'h00;
    req  = 8'hC8;
    step();
    check_out("t6_noreq", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h00;
    step();
    check_out("t6_drop", 8'h00, 3'd0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
